div32_seq: RTL and testbench

Unsigned 32-bit sequential restoring divider that computes quotient and remainder one bit per cycle. Each iteration runs one trial subtraction through the team's `cla32` adder, fed with `b` inverted and carry-in 1. It sits beside the datapath adder as the division unit and uses a start/done handshake.

---
 rtl/div32_seq_pkg.sv | 14 +
 rtl/div32_seq_if.sv | 20 ++
 rtl/div32_seq_cla32.sv | 38 +++
 rtl/div32_seq.sv | 138 +++++++++++++
 tb/tb_div32_seq.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/div32_seq_pkg.sv
// Shared constants and types for the 32-bit sequential restoring divider.
package div32_seq_pkg;

   localparam int DIV_W    = 32;
   localparam int DIV_ITER = 32;
   localparam int CNT_W    = 5;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/div32_seq_if.sv
// Request/result bundle between a divider client and div32_seq.
interface div32_seq_if;
   import div32_seq_pkg::*;

   // start is taken only while the divider is idle or pulsing done; a and b are
   // captured on that same edge. done is a one-cycle pulse, and q/r/dz stay
   // valid from the done cycle until the next accepted start or reset.
   logic             start;
   logic [DIV_W-1:0] a;
   logic [DIV_W-1:0] b;
   logic             busy;
   logic             done;
   logic [DIV_W-1:0] q;
   logic [DIV_W-1:0] r;
   logic             dz;

   modport master (output start, a, b, input busy, done, q, r, dz);
   modport slave  (input start, a, b, output busy, done, q, r, dz);

endinterface

// File: rtl/div32_seq_cla32.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups, group carries chained.
module cla32 (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        ci,
   output logic [31:0] s,
   output logic        co
);

   logic [31:0] p;
   logic [31:0] g;
   logic [8:0]  gc;

   assign p     = a ^ b;
   assign g     = a & b;
   assign gc[0] = ci;
   assign co    = gc[8];

   for (genvar gi = 0; gi < 8; gi++) begin : g_grp
      logic [3:0] gp;
      logic [3:0] gg;
      logic [4:0] c;

      assign gp   = p[4*gi +: 4];
      assign gg   = g[4*gi +: 4];
      assign c[0] = gc[gi];
      assign c[1] = gg[0] | (gp[0] & c[0]);
      assign c[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c[0]);
      assign c[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                  | (gp[2] & gp[1] & gp[0] & c[0]);
      assign c[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                  | (gp[3] & gp[2] & gp[1] & gg[0]) | ((&gp) & c[0]);

      assign s[4*gi +: 4] = gp ^ c[3:0];
      assign gc[gi+1]     = c[4];
   end

endmodule

// File: rtl/div32_seq.sv
// Unsigned 32-bit restoring divider, one quotient bit per cycle, with a cla32
// trial subtractor and a start/done handshake.
module div32_seq
   import div32_seq_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   div32_seq_if.slave  dif,
   output state_t      state_dbg
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITER - 1);

   state_t           state;
   state_t           state_next;
   logic             busy_q;
   logic             done_q;
   logic             busy_n;
   logic             done_n;
   logic             accept;
   logic             last;

   logic [DIV_W-1:0] rem;
   logic [DIV_W-1:0] quo;
   logic [DIV_W-1:0] divisor;
   logic [CNT_W-1:0] count;
   logic [DIV_W-1:0] q_q;
   logic [DIV_W-1:0] r_q;
   logic             dz_q;

   logic [DIV_W:0]   shifted;
   logic [DIV_W-1:0] diff;
   logic             co;
   logic             ok;
   logic [DIV_W-1:0] rem_n;
   logic [DIV_W-1:0] quo_n;

   assign last = (count == CNT_LAST);

   // Trial subtraction shifted - divisor as shifted + ~divisor + 1.
   assign shifted = {rem, quo[DIV_W-1]};

   cla32 u_sub (
      .a  (shifted[DIV_W-1:0]),
      .b  (~divisor),
      .ci (1'b1),
      .s  (diff),
      .co (co)
   );

   // rem < divisor keeps shifted < 2*divisor, so a set bit 32 means no borrow.
   assign ok    = shifted[DIV_W] | co;
   assign rem_n = ok ? diff : shifted[DIV_W-1:0];
   assign quo_n = {quo[DIV_W-2:0], ok};

   always_comb begin
      state_next = state;
      busy_n     = 1'b0;
      done_n     = 1'b0;
      accept     = 1'b0;
      case (state)
         S_IDLE, S_DONE: begin
            state_next = S_IDLE;
            if (dif.start) begin
               accept = 1'b1;
               if (dif.b == '0) begin
                  state_next = S_DONE;
                  done_n     = 1'b1;
               end else begin
                  state_next = S_BUSY;
                  busy_n     = 1'b1;
               end
            end
         end
         S_BUSY: begin
            if (last) begin
               state_next = S_DONE;
               done_n     = 1'b1;
            end else begin
               busy_n = 1'b1;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= S_IDLE;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state  <= state_next;
         busy_q <= busy_n;
         done_q <= done_n;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rem     <= '0;
         quo     <= '0;
         divisor <= '0;
         count   <= '0;
         q_q     <= '0;
         r_q     <= '0;
         dz_q    <= 1'b0;
      end else if (accept) begin
         divisor <= dif.b;
         if (dif.b == '0) begin
            q_q  <= '1;
            r_q  <= dif.a;
            dz_q <= 1'b1;
         end else begin
            rem   <= '0;
            quo   <= dif.a;
            count <= '0;
            dz_q  <= 1'b0;
         end
      end else if (state == S_BUSY) begin
         rem   <= rem_n;
         quo   <= quo_n;
         count <= count + CNT_W'(1);
         if (last) begin
            q_q <= quo_n;
            r_q <= rem_n;
         end
      end
   end

   assign dif.busy  = busy_q;
   assign dif.done  = done_q;
   assign dif.q     = q_q;
   assign dif.r     = r_q;
   assign dif.dz    = dz_q;
   assign state_dbg = state;

endmodule

// File: tb/tb_div32_seq.sv
// Randomized scoreboard bench for div32_seq against a plain a/b, a%b model.
module tb_div32_seq;
  import div32_seq_pkg::*;

  logic   clk;
  logic   reset;
  state_t state_dbg;

  div32_seq_if dif ();

  div32_seq dut (
    .clk       (clk),
    .reset     (reset),
    .dif       (dif.slave),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [64:0] exp_q[$];   // {q, r, dz}
  int          exp_cyc_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          busy_from = 1;
  int          busy_to = 0;
  bit          mon_en = 1'b0;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [64:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return {32'hFFFF_FFFF, a, 1'b1};
    return {a / b, a % b, 1'b0};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    exp_q.push_back(ref_div(a, b));
    if (b == 0) begin
      exp_cyc_q.push_back(cyc + 1);
    end else begin
      exp_cyc_q.push_back(cyc + 33);
      busy_from = cyc + 1;
      busy_to   = cyc + 32;
    end
    dif.start = 1'b1;
    dif.a     = a;
    dif.b     = b;
    @(negedge clk);
    dif.start = 1'b0;
    dif.a     = $urandom;
    dif.b     = $urandom;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!dif.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!dif.done) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: no done within 40 cycles, got done=0 expected 1 (cycle %0d)", cyc);
      exp_q.delete();
      exp_cyc_q.delete();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- monitor ----------------
  always begin
    @(negedge clk);
    #1;
    if (mon_en) begin
      chk("busy", 65'(dif.busy), 65'((cyc >= busy_from && cyc <= busy_to) ? 1 : 0));
      if (dif.done) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done: got done=1 expected 0 (cycle %0d)", cyc);
        end else begin
          logic [64:0] e;
          int          ec;
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          chk("result_q_r_dz", {dif.q, dif.r, dif.dz}, e);
          chk("done_cycle", 65'(cyc), 65'(ec));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    int          sel;

    reset     = 1'b1;
    dif.start = 1'b0;
    dif.a     = '0;
    dif.b     = '0;
    idle(3);
    chk("reset_busy",  65'(dif.busy), 65'(0));
    chk("reset_done",  65'(dif.done), 65'(0));
    chk("reset_q_r_dz", {dif.q, dif.r, dif.dz}, 65'(0));
    chk("reset_state", 65'(state_dbg), 65'(S_IDLE));
    reset  = 1'b0;
    mon_en = 1'b1;
    idle(2);

    start_op(32'd100, 32'd7);                 wait_done();
    idle(1);
    start_op(32'hFFFF_FFFF, 32'h8000_0001);   wait_done();
    idle(1);
    start_op(32'hFFFF_FFFF, 32'd1);           wait_done();
    idle(2);
    start_op(32'd5, 32'd0);                   wait_done();
    start_op(32'd3, 32'd10);                  wait_done();
    idle(2);

    // start mid-iteration must be ignored, then start held in the done cycle
    start_op(32'd100, 32'd7);
    idle(9);
    dif.start = 1'b1;
    dif.a     = 32'd9;
    dif.b     = 32'd2;
    @(negedge clk);
    dif.start = 1'b0;
    wait_done();
    start_op(32'd9, 32'd2);                   wait_done();
    idle(2);

    // reset in the middle of an operation
    start_op(32'd1000, 32'd3);
    idle(15);
    reset   = 1'b1;
    busy_to = cyc;
    exp_q.delete();
    exp_cyc_q.delete();
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_busy",  65'(dif.busy), 65'(0));
    chk("midreset_done",  65'(dif.done), 65'(0));
    chk("midreset_q_r_dz", {dif.q, dif.r, dif.dz}, 65'(0));
    chk("midreset_state", 65'(state_dbg), 65'(S_IDLE));
    idle(40);
    start_op(32'd1000, 32'd3);                wait_done();
    idle(1);

    for (int i = 0; i < 1500; i++) begin
      sel = $urandom_range(0, 9);
      ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 1000)) : $urandom;
      case (sel)
        0:       rb = 32'd0;
        1, 2, 3: rb = 32'($urandom_range(1, 255));
        4:       rb = ra + 32'($urandom_range(1, 100));
        5:       rb = 32'h8000_0000 | $urandom;
        default: rb = $urandom;
      endcase
      start_op(ra, rb);
      wait_done();
      idle($urandom_range(0, 2));
    end

    idle(5);
    chk("pending_results", 65'(exp_q.size()), 65'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
